pc_redirect_ctrl: RTL

- Control-side counterpart of the fetch-stage PC select mux; it generates the mux select rather than consuming it.
- Resolves EX-stage jump and branch outcomes into `pc_sel`, `pc_we`, and the IF/ID flush strobes.
- Sequences the post-reset boot hold.
- Captures a redirect target when fetch is stalled, because the writeback forwarding path changes during a stall. It drives the captured target on `hold_target`, which the PC mux uses for `pc_sel`=3.

---
 rtl/pc_redirect_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Fetch PC select / write-enable / flush control with boot hold
//               and stall-time redirect target capture.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_jump,
    input  logic             ex_branch,
    input  logic             br_taken,
    input  logic             ex_fwd,
    input  logic [31:0]      alu,
    input  logic [31:0]      alu_forward,
    input  logic             clr_cnt,
    output logic [1:0]       pc_sel,
    output logic             pc_we,
    output logic             flush_if,
    output logic             flush_id,
    output logic [31:0]      hold_target,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int              c_BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [c_BW-1:0] c_BOOT_LAST = c_BW'(BOOT_CYCLES - 1);

    localparam logic [1:0] c_SEL_ADD4 = 2'd0;
    localparam logic [1:0] c_SEL_ALU  = 2'd1;
    localparam logic [1:0] c_SEL_FWD  = 2'd2;
    localparam logic [1:0] c_SEL_HOLD = 2'd3;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_BW-1:0]   r_boot_cnt;
    logic [31:0]       r_hold_target;
    logic [CNT_W-1:0]  r_redirect_cnt;

    logic              w_redirect_req;
    logic [31:0]       w_target;
    logic              w_capture;
    logic              w_count;

    assign w_redirect_req = ex_valid & (ex_jump | (ex_branch & br_taken));
    assign w_target       = ex_fwd ? alu_forward : alu;
    // Every redirect is counted once, at the edge where RUN first sees it.
    assign w_count        = (r_state == S_RUN) & w_redirect_req;
    assign w_capture      = w_count & stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_BOOT;
            r_boot_cnt     <= '0;
            r_hold_target  <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_BOOT) begin
                r_boot_cnt <= (r_boot_cnt == c_BOOT_LAST) ? '0 : r_boot_cnt + c_BW'(1);
            end

            if (w_capture) begin
                r_hold_target <= w_target & ~32'h1;
            end

            if (clr_cnt) begin
                r_redirect_cnt <= '0;
            end else if (w_count && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        pc_sel           = c_SEL_ADD4;
        pc_we            = 1'b0;
        flush_if         = 1'b0;
        flush_id         = 1'b0;
        redirect_pending = 1'b0;

        case (r_state)
            S_BOOT: begin
                flush_if = 1'b1;
                flush_id = 1'b1;
                if (r_boot_cnt == c_BOOT_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    pc_we = 1'b1;
                    if (w_redirect_req) begin
                        pc_sel   = ex_fwd ? c_SEL_FWD : c_SEL_ALU;
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                    end
                end else if (w_redirect_req) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // The frozen EX instruction is still presented; only stall release matters.
                redirect_pending = 1'b1;
                pc_sel           = c_SEL_HOLD;
                if (!stall) begin
                    pc_we       = 1'b1;
                    flush_if    = 1'b1;
                    flush_id    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign hold_target  = r_hold_target;
    assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire
